// File: rtl/divider16_seq.sv
// divider16_seq: multi-cycle restoring divider, 2N-bit dividend / N-bit divisor with start/busy/done handshake.
module divider16_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           error,
  output logic           busy,
  output logic           done
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, TRIAL, FINISH} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  d_q, d_d, r_q, r_d, l_q, l_d, qw_q, qw_d, quo_q, quo_d, rem_q, rem_d;
  logic [N:0]    t_q, t_d, diff;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d, err_q, err_d, busy_q, busy_d, done_q, done_d, ge;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign error     = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    l_d     = l_q;
    qw_d    = qw_q;
    t_d     = t_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ge      = t_q >= {1'b0, d_q};
    diff    = t_q - {1'b0, d_q};
    case (state_q)
      IDLE: if (start) begin
        d_d     = divisor;
        r_d     = dividend[2*N-1:N];
        l_d     = dividend[N-1:0];
        qw_d    = '0;
        idx_d   = '0;
        busy_d  = 1'b1;
        // Upper half >= divisor means the quotient cannot fit in N bits.
        ovf_d   = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
        state_d = ovf_d ? FINISH : SHIFT;
      end
      SHIFT: begin
        t_d     = {r_q, l_q[N-1]};
        l_d     = l_q << 1;
        state_d = TRIAL;
      end
      TRIAL: begin
        r_d     = ge ? diff[N-1:0] : t_q[N-1:0];
        qw_d    = {qw_q[N-2:0], ge};
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == IW'(N - 1)) ? FINISH : SHIFT;
      end
      FINISH: begin
        quo_d   = ovf_q ? '1 : qw_q;
        rem_d   = ovf_q ? '1 : r_q;
        err_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      r_q     <= '0;
      l_q     <= '0;
      qw_q    <= '0;
      t_q     <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      l_q     <= l_d;
      qw_q    <= qw_d;
      t_q     <= t_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_divider16_seq.sv
// tb_divider16_seq: table vectors, hand sequences and random ops with a scoreboard queue for divider16_seq.
module tb_divider16_seq;
  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        e;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [7:0]  quotient, remainder;
  logic        error, busy, done;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        sb[$];
  vec_t        tbl[11];
  divider16_seq #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .error(error), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t golden(input logic [15:0] dd, input logic [7:0] dv);
    vec_t v;
    v.dd = dd;
    v.dv = dv;
    v.e  = (dv == 0) || (dd[15:8] >= dv);
    v.q  = v.e ? 8'hFF : 8'(dd / dv);
    v.r  = v.e ? 8'hFF : 8'(dd % dv);
    return v;
  endfunction
  task automatic compare_result(input string tag);
    vec_t x;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    x = sb.pop_front();
    check({tag, "_quotient"}, quotient, x.q);
    check({tag, "_remainder"}, remainder, x.r);
    check({tag, "_error"}, error, x.e);
  endtask
  task automatic do_op(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    start = 1'b1; dividend = v.dd; divisor = v.dv;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
    cyc = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, v.e ? 2 : 18);
    check({tag, "_busy_at_done"}, busy, 0);
    compare_result(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask
  initial begin
    int cyc, ndone, first;
    vec_t v;
    tbl[0]  = '{16'h03E8, 8'd7,  8'd142, 8'd6,  1'b0};
    tbl[1]  = '{16'hFE01, 8'hFF, 8'hFF,  8'h00, 1'b0};
    tbl[2]  = '{16'h1234, 8'h00, 8'hFF,  8'hFF, 1'b1};
    tbl[3]  = '{16'h0500, 8'h05, 8'hFF,  8'hFF, 1'b1};
    tbl[4]  = '{16'h0000, 8'h01, 8'h00,  8'h00, 1'b0};
    tbl[5]  = '{16'h00FF, 8'h01, 8'hFF,  8'h00, 1'b0};
    tbl[6]  = '{16'h04FF, 8'h05, 8'hFF,  8'h04, 1'b0};
    tbl[7]  = '{16'h0064, 8'h0A, 8'h0A,  8'h00, 1'b0};
    tbl[8]  = '{16'h0001, 8'hFF, 8'h00,  8'h01, 1'b0};
    tbl[9]  = '{16'hFFFF, 8'hFF, 8'hFF,  8'hFF, 1'b1};
    tbl[10] = '{16'h7FFF, 8'h80, 8'hFF,  8'h7F, 1'b0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_error", error, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    for (int i = 0; i < 11; i++) do_op(tbl[i], $sformatf("vec%0d", i));
    // Restarts while busy must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 16'h03E8; divisor = 8'd7;
    sb.push_back(tbl[0]);
    @(negedge clk);
    start = 1'b0; cyc = 1; ndone = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("busy_start_latency", cyc, 18);
          compare_result("busy_start");
        end
      end
      start = (cyc >= 3 && cyc <= 10);
      dividend = 16'hFE01; divisor = 8'hFF;
    end
    start = 1'b0;
    check("busy_start_done_count", ndone, 1);
    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; dividend = 16'h7FFF; divisor = 8'h80;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 9) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_error", error, 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_op(tbl[0], "after_abort");
    // Start held high: back-to-back ops, done pulses 18 cycles apart.
    @(negedge clk);
    start = 1'b1; dividend = 16'h0064; divisor = 8'h0A;
    sb.push_back(tbl[7]);
    sb.push_back(tbl[7]);
    cyc = 0; ndone = 0; first = 0;
    while (ndone < 2 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        compare_result("b2b");
        if (ndone == 1) first = cyc;
        else begin
          start = 1'b0;
          check("b2b_gap", cyc - first, 18);
        end
      end
    end
    start = 1'b0;
    check("b2b_done_count", ndone, 2);
    @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] dv;
      logic [15:0] dd;
      dv = 8'($urandom);
      dd = 16'($urandom);
      if (i % 50 == 0) dv = 8'd1;
      if (i % 37 == 0) dd = 16'd0;
      if (i % 4 != 0 && dv != 0) dd[15:8] = 8'($urandom_range(0, int'(dv) - 1));
      v = golden(dd, dv);
      do_op(v, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
